// File: rtl/vi_mem_pkg.sv
// Shared types and default widths for the main-memory arbiter.
package vi_mem_pkg;
    localparam int ADDR_W  = 20;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_IC = 1'b0,
        GRANT_DC = 1'b1
    } grant_t;
endpackage

// File: rtl/mem_arb_grant.sv
// Grant select between icache and dcache; MEM_ARB_RR_EN enables round-robin
// with a last_grant register, otherwise dcache has fixed priority.
module mem_arb_grant
    import vi_mem_pkg::*;
(
    input  logic   clk_i,
    input  logic   rsn_i,
    input  logic   ic_rqst_i,
    input  logic   dc_rqst_i,
    input  logic   take_i,
    output grant_t grant_o
);

`ifdef MEM_ARB_RR_EN
    grant_t last_grant_r;

    // Remember who was granted last so a tie goes to the other side.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            last_grant_r <= GRANT_IC;
        end else if (take_i) begin
            last_grant_r <= grant_o;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Tie resolved against last_grant, single requester wins outright.
    always_comb begin
        if (ic_rqst_i && dc_rqst_i) begin
            grant_o = (last_grant_r == GRANT_IC) ? GRANT_DC : GRANT_IC;
        end else if (dc_rqst_i) begin
            grant_o = GRANT_DC;
        end else begin
            grant_o = GRANT_IC;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{clk_i, rsn_i, ic_rqst_i, take_i};

    // Fixed priority: dcache wins any tie.
    always_comb begin
        if (dc_rqst_i) begin
            grant_o = GRANT_DC;
        end else begin
            grant_o = GRANT_IC;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory request/ack port between icache refills and dcache
// refill/write-back. Optional round-robin tie-break via MEM_ARB_RR_EN.
module mem_arbiter #(
    parameter int ADDR_W  = 20,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              ic_rqst_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_data_ready_o,
    output logic [LINE_W-1:0] ic_data_o,
    input  logic              dc_rqst_i,
    input  logic              dc_wr_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [LINE_W-1:0] dc_wr_data_i,
    output logic              dc_data_ready_o,
    output logic [LINE_W-1:0] dc_data_o,
    output logic              mem_rqst_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wr_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              timeout_o
);
    import vi_mem_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_r, state_next_s;
    grant_t            grant_s, grant_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic              wr_r;
    logic [LINE_W-1:0] wr_data_r;
    logic              take_s;
    logic              mem_rqst_r, ic_ready_r, dc_ready_r, timeout_r;
    logic [LINE_W-1:0] ic_data_r, dc_data_r;
    logic              mem_rqst_next_s, ic_ready_next_s, dc_ready_next_s, timeout_next_s;
    logic [LINE_W-1:0] line_next_s, ic_data_next_s, dc_data_next_s;

    assign take_s = (state_r == IDLE) && (ic_rqst_i || dc_rqst_i);

    mem_arb_grant u_grant (
        .clk_i     (clk_i),
        .rsn_i     (rsn_i),
        .ic_rqst_i (ic_rqst_i),
        .dc_rqst_i (dc_rqst_i),
        .take_i    (take_s),
        .grant_o   (grant_s)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: ack beats timeout in WAIT.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = (ic_rqst_i || dc_rqst_i) ? WAIT : IDLE;
            WAIT:    state_next_s = (mem_ack_i || (cnt_r == CNT_LAST)) ? RESP : WAIT;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; RESP is entered only from WAIT.
    always_comb begin
        mem_rqst_next_s = (state_next_s == WAIT);
        if (mem_ack_i && !wr_r) begin
            line_next_s = mem_data_i;
        end else begin
            line_next_s = '0;
        end
        if ((state_r == WAIT) && (state_next_s == RESP)) begin
            ic_ready_next_s = (grant_r == GRANT_IC);
            dc_ready_next_s = (grant_r == GRANT_DC);
            timeout_next_s  = !mem_ack_i;
        end else begin
            ic_ready_next_s = 1'b0;
            dc_ready_next_s = 1'b0;
            timeout_next_s  = 1'b0;
        end
        ic_data_next_s = ic_ready_next_s ? line_next_s : '0;
        dc_data_next_s = dc_ready_next_s ? line_next_s : '0;
    end

    // Registered outputs toward requesters and memory.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            mem_rqst_r <= 1'b0;
            ic_ready_r <= 1'b0;
            dc_ready_r <= 1'b0;
            timeout_r  <= 1'b0;
            ic_data_r  <= '0;
            dc_data_r  <= '0;
        end else begin
            mem_rqst_r <= mem_rqst_next_s;
            ic_ready_r <= ic_ready_next_s;
            dc_ready_r <= dc_ready_next_s;
            timeout_r  <= timeout_next_s;
            ic_data_r  <= ic_data_next_s;
            dc_data_r  <= dc_data_next_s;
        end
    end

    // Request latch taken at grant, plus the WAIT cycle counter.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            grant_r   <= GRANT_IC;
            addr_r    <= '0;
            wr_r      <= 1'b0;
            wr_data_r <= '0;
            cnt_r     <= '0;
        end else begin
            if (take_s) begin
                grant_r <= grant_s;
                if (grant_s == GRANT_DC) begin
                    addr_r    <= dc_addr_i;
                    wr_r      <= dc_wr_i;
                    wr_data_r <= dc_wr_data_i;
                end else begin
                    addr_r    <= ic_addr_i;
                    wr_r      <= 1'b0;
                    wr_data_r <= '0;
                end
            end else begin
                grant_r   <= grant_r;
                addr_r    <= addr_r;
                wr_r      <= wr_r;
                wr_data_r <= wr_data_r;
            end
            if (state_r == WAIT) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign mem_rqst_o      = mem_rqst_r;
    assign mem_wr_o        = wr_r;
    assign mem_addr_o      = addr_r;
    assign mem_wr_data_o   = wr_data_r;
    assign ic_data_ready_o = ic_ready_r;
    assign dc_data_ready_o = dc_ready_r;
    assign ic_data_o       = ic_data_r;
    assign dc_data_o       = dc_data_r;
    assign timeout_o       = timeout_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: bench plays both caches and the memory,
// and a transaction-level model predicts grant order, latency and returned lines.
module tb_mem_arbiter;
    localparam int AW  = 20;
    localparam int LW  = 128;
    localparam int TMO = 64;

    logic          clk_i = 1'b0;
    logic          rsn_i;
    logic          ic_rqst_i, dc_rqst_i, dc_wr_i, mem_ack_i;
    logic [AW-1:0] ic_addr_i, dc_addr_i;
    logic [LW-1:0] dc_wr_data_i, mem_data_i;
    logic          ic_data_ready_o, dc_data_ready_o, mem_rqst_o, mem_wr_o, timeout_o;
    logic [LW-1:0] ic_data_o, dc_data_o, mem_wr_data_o;
    logic [AW-1:0] mem_addr_o;

    int checks = 0;
    int errors = 0;

    // Model of the requesters' outstanding work.
    bit            ic_pend = 1'b0, dc_pend = 1'b0, dc_w = 1'b0;
    logic [AW-1:0] ic_a = '0, dc_a = '0;
    logic [LW-1:0] dc_wd = '0;
    bit            last_dc = 1'b0;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .ic_rqst_i(ic_rqst_i), .ic_addr_i(ic_addr_i),
        .ic_data_ready_o(ic_data_ready_o), .ic_data_o(ic_data_o),
        .dc_rqst_i(dc_rqst_i), .dc_wr_i(dc_wr_i), .dc_addr_i(dc_addr_i),
        .dc_wr_data_i(dc_wr_data_i),
        .dc_data_ready_o(dc_data_ready_o), .dc_data_o(dc_data_o),
        .mem_rqst_o(mem_rqst_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive();
        ic_rqst_i    = ic_pend;
        ic_addr_i    = ic_a;
        dc_rqst_i    = dc_pend;
        dc_addr_i    = dc_a;
        dc_wr_i      = dc_w;
        dc_wr_data_i = dc_wd;
    endtask

    task automatic new_reqs(input int pct);
        if (!ic_pend && ($urandom_range(99) < pct)) begin
            ic_pend = 1'b1;
            ic_a    = AW'($urandom_range(20'hFFFFF));
        end
        if (!dc_pend && ($urandom_range(99) < pct)) begin
            dc_pend = 1'b1;
            dc_a    = AW'($urandom_range(20'hFFFFF));
            dc_w    = $urandom_range(1) == 1;
            dc_wd   = rand_line();
        end
        drive();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rqst"}, {127'd0, mem_rqst_o}, 128'd0);
        check({tag, "_icrdy"}, {127'd0, ic_data_ready_o}, 128'd0);
        check({tag, "_dcrdy"}, {127'd0, dc_data_ready_o}, 128'd0);
        check({tag, "_icdat"}, ic_data_o, 128'd0);
        check({tag, "_dcdat"}, dc_data_o, 128'd0);
        check({tag, "_tmo"}, {127'd0, timeout_o}, 128'd0);
    endtask

    // Serve one transaction at a time; d<0 means memory never acks.
    // Called at a negedge with requests already driven.
    task automatic serve(input int d, input logic [LW-1:0] line);
        bit            win_dc;
        bit            exp_wr;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_wd, exp_line;
        int            cnt, exp_len;
        if (ic_pend && dc_pend) begin
`ifdef MEM_ARB_RR_EN
            win_dc = !last_dc;
`else
            win_dc = 1'b1;
`endif
        end else begin
            win_dc = dc_pend;
        end
        last_dc  = win_dc;
        exp_addr = win_dc ? dc_a : ic_a;
        exp_wr   = win_dc && dc_w;
        exp_wd   = dc_wd;
        exp_len  = (d >= 0) ? d + 1 : TMO;
        exp_line = (d < 0 || exp_wr) ? '0 : line;

        @(negedge clk_i);
        check("rqst_latency", {127'd0, mem_rqst_o}, 128'd1);
        if (!mem_rqst_o) begin
            return;
        end
        check("mem_addr", {108'd0, mem_addr_o}, {108'd0, exp_addr});
        check("mem_wr", {127'd0, mem_wr_o}, {127'd0, exp_wr});
        if (exp_wr) begin
            check("mem_wr_data", mem_wr_data_o, exp_wd);
        end
        cnt = 1;
        while (mem_rqst_o && cnt <= TMO + 4) begin
            if (d >= 0 && cnt == d + 1) begin
                mem_ack_i  = 1'b1;
                mem_data_i = line;
            end
            @(negedge clk_i);
            mem_ack_i  = 1'b0;
            mem_data_i = rand_line();
            if (mem_rqst_o) begin
                cnt++;
            end
        end
        check("rqst_len", LW'(cnt), LW'(exp_len));
        check("ic_ready", {127'd0, ic_data_ready_o}, {127'd0, !win_dc});
        check("dc_ready", {127'd0, dc_data_ready_o}, {127'd0, win_dc});
        check("ic_data", ic_data_o, win_dc ? 128'd0 : exp_line);
        check("dc_data", dc_data_o, win_dc ? exp_line : 128'd0);
        check("timeout", {127'd0, timeout_o}, {127'd0, d < 0});
        // Stray ack in RESP must be ignored.
        mem_ack_i  = 1'b1;
        mem_data_i = rand_line();
        if (win_dc) begin
            dc_pend = 1'b0;
        end else begin
            ic_pend = 1'b0;
        end
        drive();
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        check_idle_outputs("after_resp");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rsn_i      = 1'b0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        drive();
        #1;
        check_idle_outputs("reset");
        check("reset_addr", {108'd0, mem_addr_o}, 128'd0);
        check("reset_wr", {127'd0, mem_wr_o}, 128'd0);
        repeat (3) @(negedge clk_i);
        rsn_i = 1'b1;
        @(negedge clk_i);

        // Single icache refill.
        ic_pend = 1'b1; ic_a = 20'h00040;
        drive();
        serve(1, {16{8'hA5}});

        // Simultaneous requests.
        ic_pend = 1'b1; ic_a = 20'h00200;
        dc_pend = 1'b1; dc_a = 20'h00100; dc_w = 1'b0;
        drive();
        serve(2, rand_line());
        serve(0, rand_line());

        // Dcache write-back.
        dc_pend = 1'b1; dc_a = 20'h00300; dc_w = 1'b1; dc_wd = 128'h1234;
        drive();
        serve(3, rand_line());

        // Memory never answers.
        ic_pend = 1'b1; ic_a = 20'h00badd;
        drive();
        serve(-1, rand_line());

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            while (!ic_pend && !dc_pend) begin
                new_reqs(50);
            end
            serve(($urandom_range(15) == 0) ? -1 : int'($urandom_range(5)), rand_line());
            new_reqs(40);
        end

        // Asynchronous reset in the middle of WAIT.
        ic_pend = 1'b0; dc_pend = 1'b1; dc_a = 20'h00777; dc_w = 1'b0;
        drive();
        repeat (3) @(negedge clk_i);
        check("pre_rst_rqst", {127'd0, mem_rqst_o}, 128'd1);
        #2;
        rsn_i = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        dc_pend = 1'b0;
        last_dc = 1'b0;
        drive();
        @(negedge clk_i);
        rsn_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_idle_outputs("post_reset");
        ic_pend = 1'b1; ic_a = 20'h00123;
        dc_pend = 1'b1; dc_a = 20'h00456; dc_w = 1'b0;
        drive();
        serve(1, rand_line());
        serve(4, rand_line());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
